// File: rtl/up_adc_bus_agg.sv
// Register-bus response aggregator for multi-channel ADC cores: merges slave acks/data,
// aggregates channel status, and guards each access direction with a timeout.
module up_adc_bus_agg #(
  parameter int unsigned NUM_SLAVES     = 3,
  parameter int unsigned NUM_CHANNELS   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADDEAD
) (
  input  logic                       up_clk,
  input  logic                       up_rstn,
  input  logic                       up_wreq,
  input  logic                       up_rreq,
  input  logic [NUM_SLAVES-1:0]      up_slv_wack,
  input  logic [NUM_SLAVES-1:0]      up_slv_rack,
  input  logic [32*NUM_SLAVES-1:0]   up_slv_rdata,
  output logic                       up_wack,
  output logic                       up_rack,
  output logic [31:0]                up_rdata,
  input  logic [NUM_CHANNELS-1:0]    up_ch_pn_err,
  input  logic [NUM_CHANNELS-1:0]    up_ch_pn_oos,
  input  logic [NUM_CHANNELS-1:0]    up_ch_or,
  input  logic                       up_status_clr,
  output logic                       up_status_pn_err,
  output logic                       up_status_pn_oos,
  output logic                       up_status_or,
  output logic                       up_status_or_sticky,
  output logic                       up_ack_collision,
  output logic [15:0]                up_timeout_count
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {TRK_IDLE, TRK_WAIT} trk_e;

  trk_e            rd_st_q, rd_st_d, wr_st_q, wr_st_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic            rd_to, wr_to;

  logic            rack_q, rack_d, wack_q, wack_d;
  logic [31:0]     rdata_q, rdata_d, rdata_or;
  logic            pn_err_q, pn_oos_q, or_q;
  logic            sticky_q, sticky_d, coll_q, coll_d, coll_now;
  logic [15:0]     tmo_cnt_q, tmo_cnt_d;
  logic [16:0]     tmo_sum;

  always_comb begin
    rd_st_d  = rd_st_q;
    rd_cnt_d = rd_cnt_q;
    rd_to    = 1'b0;
    case (rd_st_q)
      TRK_IDLE: if (up_rreq) begin
        rd_st_d  = TRK_WAIT;
        rd_cnt_d = '0;
      end
      TRK_WAIT: begin
        if (|up_slv_rack) begin
          rd_st_d = TRK_IDLE;
        end else if (rd_cnt_q == CNT_LAST) begin
          rd_st_d = TRK_IDLE;
          rd_to   = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q + CW'(1);
        end
      end
      default: rd_st_d = TRK_IDLE;
    endcase
  end

  always_comb begin
    wr_st_d  = wr_st_q;
    wr_cnt_d = wr_cnt_q;
    wr_to    = 1'b0;
    case (wr_st_q)
      TRK_IDLE: if (up_wreq) begin
        wr_st_d  = TRK_WAIT;
        wr_cnt_d = '0;
      end
      TRK_WAIT: begin
        if (|up_slv_wack) begin
          wr_st_d = TRK_IDLE;
        end else if (wr_cnt_q == CNT_LAST) begin
          wr_st_d = TRK_IDLE;
          wr_to   = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q + CW'(1);
        end
      end
      default: wr_st_d = TRK_IDLE;
    endcase
  end

  always_comb begin
    rdata_or = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (up_slv_rack[k]) rdata_or = rdata_or | up_slv_rdata[32*k +: 32];
    end
  end

  // x & (x-1) is non-zero exactly when two or more bits of x are set
  always_comb begin
    coll_now = ((up_slv_rack & (up_slv_rack - NUM_SLAVES'(1))) != '0) ||
               ((up_slv_wack & (up_slv_wack - NUM_SLAVES'(1))) != '0);
    rack_d   = (|up_slv_rack) | rd_to;
    wack_d   = (|up_slv_wack) | wr_to;
    rdata_d  = rd_to ? TIMEOUT_DATA : rdata_or;
    sticky_d = (|up_ch_or) | (sticky_q & ~up_status_clr);
    coll_d   = coll_now | (coll_q & ~up_status_clr);
    tmo_sum  = {1'b0, tmo_cnt_q} + {16'd0, rd_to} + {16'd0, wr_to};
    if (rd_to || wr_to) begin
      tmo_cnt_d = tmo_sum[16] ? 16'hFFFF : tmo_sum[15:0];
    end else if (up_status_clr) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      rd_st_q   <= TRK_IDLE;
      wr_st_q   <= TRK_IDLE;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      rack_q    <= 1'b0;
      wack_q    <= 1'b0;
      rdata_q   <= '0;
      pn_err_q  <= 1'b0;
      pn_oos_q  <= 1'b0;
      or_q      <= 1'b0;
      sticky_q  <= 1'b0;
      coll_q    <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      rd_st_q   <= rd_st_d;
      wr_st_q   <= wr_st_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rack_q    <= rack_d;
      wack_q    <= wack_d;
      rdata_q   <= rdata_d;
      pn_err_q  <= |up_ch_pn_err;
      pn_oos_q  <= |up_ch_pn_oos;
      or_q      <= |up_ch_or;
      sticky_q  <= sticky_d;
      coll_q    <= coll_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign up_rack             = rack_q;
  assign up_wack             = wack_q;
  assign up_rdata            = rdata_q;
  assign up_status_pn_err    = pn_err_q;
  assign up_status_pn_oos    = pn_oos_q;
  assign up_status_or        = or_q;
  assign up_status_or_sticky = sticky_q;
  assign up_ack_collision    = coll_q;
  assign up_timeout_count    = tmo_cnt_q;

endmodule

// File: tb/tb_up_adc_bus_agg.sv
// Self-checking bench for up_adc_bus_agg: vector table, directed multi-cycle sequences,
// and randomized traffic against a deadline-based reference model.
module tb_up_adc_bus_agg;
  localparam int unsigned NS = 3;
  localparam int unsigned NC = 4;
  localparam int unsigned TC = 32;
  localparam logic [31:0] TD = 32'hDEADDEAD;

  logic          up_clk = 1'b0;
  logic          up_rstn = 1'b0;
  logic          up_wreq, up_rreq;
  logic [NS-1:0] up_slv_wack, up_slv_rack;
  logic [32*NS-1:0] up_slv_rdata;
  logic          up_wack, up_rack;
  logic [31:0]   up_rdata;
  logic [NC-1:0] up_ch_pn_err, up_ch_pn_oos, up_ch_or;
  logic          up_status_clr;
  logic          up_status_pn_err, up_status_pn_oos, up_status_or, up_status_or_sticky;
  logic          up_ack_collision;
  logic [15:0]   up_timeout_count;

  int total = 0;
  int bad   = 0;

  up_adc_bus_agg #(
    .NUM_SLAVES(NS), .NUM_CHANNELS(NC), .TIMEOUT_CYCLES(TC), .TIMEOUT_DATA(TD)
  ) dut (
    .up_clk(up_clk), .up_rstn(up_rstn), .up_wreq(up_wreq), .up_rreq(up_rreq),
    .up_slv_wack(up_slv_wack), .up_slv_rack(up_slv_rack), .up_slv_rdata(up_slv_rdata),
    .up_wack(up_wack), .up_rack(up_rack), .up_rdata(up_rdata),
    .up_ch_pn_err(up_ch_pn_err), .up_ch_pn_oos(up_ch_pn_oos), .up_ch_or(up_ch_or),
    .up_status_clr(up_status_clr), .up_status_pn_err(up_status_pn_err),
    .up_status_pn_oos(up_status_pn_oos), .up_status_or(up_status_or),
    .up_status_or_sticky(up_status_or_sticky), .up_ack_collision(up_ack_collision),
    .up_timeout_count(up_timeout_count)
  );

  always #5 up_clk = ~up_clk;

  typedef struct {
    logic [2:0]  rack;
    logic [2:0]  wack;
    logic [95:0] rdata;
    logic [3:0]  pe;
    logic [3:0]  po;
    logic [3:0]  cor;
    logic        clr;
    logic        e_rack;
    logic        e_wack;
    logic [31:0] e_rdata;
    logic [3:0]  e_stat;
    logic        e_coll;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge up_clk);
    #1;
  endtask

  task automatic idle_in();
    up_wreq = 1'b0; up_rreq = 1'b0; up_slv_wack = '0; up_slv_rack = '0;
    up_slv_rdata = '0; up_ch_pn_err = '0; up_ch_pn_oos = '0; up_ch_or = '0;
    up_status_clr = 1'b0;
  endtask

  task automatic do_reset();
    up_rstn = 1'b0;
    idle_in();
    repeat (2) cyc();
    up_rstn = 1'b1;
  endtask

  task automatic run_idle(input int n, output int racks, output int wacks);
    racks = 0;
    wacks = 0;
    repeat (n) begin
      cyc();
      racks += int'(up_rack);
      wacks += int'(up_wack);
    end
  endtask

  // Read request with no acks: synthetic ack must appear exactly TC+1 cycles later.
  task automatic read_timeout_seq(input string tag, input logic [15:0] exp_cnt);
    int r, w, early;
    up_rreq = 1'b1;
    cyc();
    early = int'(up_rack);
    up_rreq = 1'b0;
    run_idle(TC - 1, r, w);
    chk({tag, "_no_early_rack"}, 64'(early + r), 64'd0);
    cyc();
    chk({tag, "_to_rack"}, 64'(up_rack), 64'd1);
    chk({tag, "_to_rdata"}, 64'(up_rdata), 64'(TD));
    chk({tag, "_to_count"}, 64'(up_timeout_count), 64'(exp_cnt));
    cyc();
    chk({tag, "_rack_drop"}, 64'(up_rack), 64'd0);
  endtask

  task automatic both_timeout_seq(input string tag, input logic [15:0] exp_cnt);
    int r, w, early;
    up_rreq = 1'b1;
    up_wreq = 1'b1;
    cyc();
    early = int'(up_rack) + int'(up_wack);
    up_rreq = 1'b0;
    up_wreq = 1'b0;
    run_idle(TC - 1, r, w);
    chk({tag, "_no_early_ack"}, 64'(early + r + w), 64'd0);
    cyc();
    chk({tag, "_acks"}, {62'd0, up_rack, up_wack}, 64'd3);
    chk({tag, "_count"}, 64'(up_timeout_count), 64'(exp_cnt));
  endtask

  function automatic logic [3:0] stat_now();
    return {up_status_pn_err, up_status_pn_oos, up_status_or, up_status_or_sticky};
  endfunction

  initial begin
    int r, w;
    bit         m_rpend, m_wpend, m_sticky, m_coll, rto, wto;
    int         m_rdl, m_wdl;
    int         m_tmo;
    logic [2:0]  ra, wa;
    logic [95:0] rd;
    logic [3:0]  pe, po, cor;
    logic        rq, wq, clr;
    logic [31:0] exp_d;

    tbl[0] = '{3'b010, 3'b000, {32'h22222222, 32'hCAFEBABE, 32'h11111111}, 4'h0, 4'h0, 4'h0, 1'b0,
               1'b1, 1'b0, 32'hCAFEBABE, 4'b0000, 1'b0};
    tbl[1] = '{3'b000, 3'b100, {32'h33333333, 32'h44444444, 32'h55555555}, 4'h1, 4'h0, 4'h0, 1'b0,
               1'b0, 1'b1, 32'h0, 4'b1000, 1'b0};
    tbl[2] = '{3'b001, 3'b000, {32'h0, 32'hFFFFFFFF, 32'h000000AA}, 4'h0, 4'h0, 4'h4, 1'b0,
               1'b1, 1'b0, 32'h000000AA, 4'b0011, 1'b0};
    tbl[3] = '{3'b000, 3'b000, 96'h0, 4'h0, 4'h8, 4'h0, 1'b0,
               1'b0, 1'b0, 32'h0, 4'b0101, 1'b0};
    tbl[4] = '{3'b110, 3'b000, {32'h00FF0000, 32'h0000FF00, 32'hFFFFFFFF}, 4'h0, 4'h0, 4'h0, 1'b0,
               1'b1, 1'b0, 32'h00FFFF00, 4'b0001, 1'b1};
    tbl[5] = '{3'b000, 3'b000, 96'h0, 4'h0, 4'h0, 4'h1, 1'b1,
               1'b0, 1'b0, 32'h0, 4'b0011, 1'b0};
    tbl[6] = '{3'b000, 3'b000, 96'h0, 4'h0, 4'h0, 4'h0, 1'b1,
               1'b0, 1'b0, 32'h0, 4'b0000, 1'b0};
    tbl[7] = '{3'b000, 3'b111, 96'h0, 4'h0, 4'h0, 4'h0, 1'b0,
               1'b0, 1'b1, 32'h0, 4'b0000, 1'b1};
    tbl[8] = '{3'b000, 3'b000, {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC}, 4'h0, 4'h0, 4'h0, 1'b0,
               1'b0, 1'b0, 32'h0, 4'b0000, 1'b1};

    // Reset state, checked while reset is still asserted
    idle_in();
    #2;
    chk("reset_outputs", {9'd0, up_wack, up_rack, up_rdata, stat_now(), up_ack_collision,
                          up_timeout_count}, 64'd0);
    do_reset();

    // Vector table: single-cycle response path with trackers idle
    for (int i = 0; i < 9; i++) begin
      up_slv_rack = tbl[i].rack; up_slv_wack = tbl[i].wack; up_slv_rdata = tbl[i].rdata;
      up_ch_pn_err = tbl[i].pe; up_ch_pn_oos = tbl[i].po; up_ch_or = tbl[i].cor;
      up_status_clr = tbl[i].clr;
      cyc();
      chk($sformatf("vec%0d_acks", i), {62'd0, up_rack, up_wack}, {62'd0, tbl[i].e_rack, tbl[i].e_wack});
      chk($sformatf("vec%0d_rdata", i), 64'(up_rdata), 64'(tbl[i].e_rdata));
      chk($sformatf("vec%0d_status", i), 64'(stat_now()), 64'(tbl[i].e_stat));
      chk($sformatf("vec%0d_coll", i), 64'(up_ack_collision), 64'(tbl[i].e_coll));
    end

    // Normal read: slave 1 acks two cycles after the request
    do_reset();
    up_rreq = 1'b1;
    cyc();
    r = int'(up_rack);
    up_rreq = 1'b0;
    cyc();
    chk("t1_no_early_rack", 64'(r + int'(up_rack)), 64'd0);
    up_slv_rack = 3'b010;
    up_slv_rdata = {32'h0, 32'h00001234, 32'hFFFFFFFF};
    cyc();
    chk("t1_rack", 64'(up_rack), 64'd1);
    chk("t1_rdata", 64'(up_rdata), 64'h1234);
    idle_in();
    cyc();
    chk("t1_rack_one_cycle", 64'(up_rack), 64'd0);
    run_idle(40, r, w);
    chk("t1_no_late_rack", 64'(r), 64'd0);
    chk("t1_count", 64'(up_timeout_count), 64'd0);

    // Read timeout, then ack in the final counting cycle wins
    do_reset();
    read_timeout_seq("t2", 16'd1);
    up_rreq = 1'b1;
    cyc();
    up_rreq = 1'b0;
    run_idle(TC - 1, r, w);
    chk("t2b_no_early_rack", 64'(r), 64'd0);
    up_slv_rack = 3'b001;
    up_slv_rdata = {32'h0, 32'h0, 32'hA5A50001};
    cyc();
    idle_in();
    chk("t2b_rack", 64'(up_rack), 64'd1);
    chk("t2b_rdata", 64'(up_rdata), 64'hA5A50001);
    chk("t2b_count", 64'(up_timeout_count), 64'd1);
    run_idle(40, r, w);
    chk("t2b_no_late_rack", 64'(r), 64'd0);

    // Concurrent timeouts and saturation
    do_reset();
    both_timeout_seq("t3", 16'd2);
    force dut.tmo_cnt_q = 16'hFFFE;
    #1;
    release dut.tmo_cnt_q;
    chk("t3_preload", 64'(up_timeout_count), 64'hFFFE);
    both_timeout_seq("t3_sat", 16'hFFFF);
    read_timeout_seq("t3_sat_rd", 16'hFFFF);
    up_status_clr = 1'b1;
    cyc();
    up_status_clr = 1'b0;
    chk("t3_clr_count", 64'(up_timeout_count), 64'd0);

    // Collision on read and write acks
    do_reset();
    up_slv_rack = 3'b101;
    up_slv_rdata = {32'h000000F0, 32'h12345678, 32'h0000000F};
    cyc();
    idle_in();
    chk("t4_rdata", 64'(up_rdata), 64'hFF);
    chk("t4_coll", 64'(up_ack_collision), 64'd1);
    cyc();
    chk("t4_coll_sticky", 64'(up_ack_collision), 64'd1);
    up_status_clr = 1'b1;
    cyc();
    chk("t4_coll_clr", 64'(up_ack_collision), 64'd0);
    up_status_clr = 1'b1;
    up_slv_wack = 3'b011;
    cyc();
    idle_in();
    chk("t4_wcoll_set_wins", {62'd0, up_wack, up_ack_collision}, 64'd3);

    // Status aggregation and sticky over-range
    do_reset();
    up_ch_or = 4'b1000;
    up_ch_pn_err = 4'b0100;
    cyc();
    up_ch_or = '0;
    up_ch_pn_err = '0;
    up_ch_pn_oos = 4'b0001;
    chk("t5_or_pulse", 64'(stat_now()), 64'b1011);
    cyc();
    up_ch_pn_oos = '0;
    chk("t5_or_drop", 64'(stat_now()), 64'b0101);
    run_idle(5, r, w);
    chk("t5_sticky_hold", 64'(stat_now()), 64'b0001);
    up_status_clr = 1'b1;
    cyc();
    up_status_clr = 1'b0;
    chk("t5_sticky_clr", 64'(stat_now()), 64'b0000);

    // Reset in the middle of a pending read
    do_reset();
    up_rreq = 1'b1;
    cyc();
    up_rreq = 1'b0;
    run_idle(4, r, w);
    up_rstn = 1'b0;
    #1;
    chk("t6_rst_outputs", {9'd0, up_wack, up_rack, up_rdata, stat_now(), up_ack_collision,
                           up_timeout_count}, 64'd0);
    repeat (2) cyc();
    chk("t6_rst_hold", {9'd0, up_wack, up_rack, up_rdata, stat_now(), up_ack_collision,
                        up_timeout_count}, 64'd0);
    up_rstn = 1'b1;
    run_idle(50, r, w);
    chk("t6_no_rack_after_rst", 64'(r), 64'd0);
    read_timeout_seq("t6", 16'd1);

    // Randomized traffic against a deadline-based model
    do_reset();
    m_rpend = 0; m_wpend = 0; m_sticky = 0; m_coll = 0; m_tmo = 0; m_rdl = 0; m_wdl = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < 3; k++) begin
        ra[k] = ($urandom_range(0, 39) == 0);
        wa[k] = ($urandom_range(0, 39) == 0);
        rd[32*k +: 32] = $urandom;
      end
      rq  = ($urandom_range(0, 7) == 0);
      wq  = ($urandom_range(0, 7) == 0);
      pe  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      po  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      cor = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      rto = m_rpend && (ra == 3'b000) && (t == m_rdl);
      wto = m_wpend && (wa == 3'b000) && (t == m_wdl);
      clr = ($urandom_range(0, 19) == 0) && !rto && !wto;

      up_rreq = rq; up_wreq = wq; up_slv_rack = ra; up_slv_wack = wa; up_slv_rdata = rd;
      up_ch_pn_err = pe; up_ch_pn_oos = po; up_ch_or = cor; up_status_clr = clr;
      cyc();

      exp_d = 32'h0;
      for (int k = 0; k < 3; k++) if (ra[k]) exp_d = exp_d | rd[32*k +: 32];
      if (rto) exp_d = TD;
      m_sticky = (cor != 4'h0) || (m_sticky && !clr);
      m_coll = ($countones(ra) > 1) || ($countones(wa) > 1) || (m_coll && !clr);
      if (rto || wto) begin
        m_tmo = m_tmo + int'(rto) + int'(wto);
        if (m_tmo > 65535) m_tmo = 65535;
      end else if (clr) begin
        m_tmo = 0;
      end

      chk($sformatf("rnd%0d_acks", t), {62'd0, up_rack, up_wack},
          {62'd0, (ra != 3'b000) || rto, (wa != 3'b000) || wto});
      chk($sformatf("rnd%0d_rdata", t), 64'(up_rdata), 64'(exp_d));
      chk($sformatf("rnd%0d_status", t), 64'(stat_now()),
          64'({pe != 4'h0, po != 4'h0, cor != 4'h0, m_sticky}));
      chk($sformatf("rnd%0d_coll", t), 64'(up_ack_collision), 64'(m_coll));
      chk($sformatf("rnd%0d_count", t), 64'(up_timeout_count), 64'(m_tmo));

      if (m_rpend) begin
        if (ra != 3'b000 || rto) m_rpend = 0;
      end else if (rq) begin
        m_rpend = 1;
        m_rdl = t + TC;
      end
      if (m_wpend) begin
        if (wa != 3'b000 || wto) m_wpend = 0;
      end else if (wq) begin
        m_wpend = 1;
        m_wdl = t + TC;
      end
    end
    idle_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
